// File: rtl/el_timing_pkg.sv
// el_timing_pkg: shared widths, FSM state type and arithmetic helpers for the
// early-late timing controller.
//   W      - sample width (signed two's complement)
//   ACC_W  - error accumulator width (signed)
//   el_state_e - controller states IDLE / ACC / HOLD
//   abs_sat    - magnitude with the most negative code clipped to max positive
//   sat_add    - accumulator + per-pair error, saturating at +/-(2^(ACC_W-1)-1)
package el_timing_pkg;

    localparam int W     = 16;
    localparam int ACC_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } el_state_e;

    // |x| with -2^(W-1) mapped to 2^(W-1)-1 so the result always fits in W bits
    function automatic logic signed [W-1:0] abs_sat(input logic signed [W-1:0] x);
        logic signed [W-1:0] r;
        if (x[W-1] == 1'b0) begin
            r = x;
        end else if (x == {1'b1, {(W-1){1'b0}}}) begin
            r = {1'b0, {(W-1){1'b1}}};
        end else begin
            r = -x;
        end
        return r;
    endfunction

    // Symmetric saturating add; the extra top bit of sum_v catches overflow
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [W:0]       e
    );
        logic signed [ACC_W:0]   sum_v;
        logic signed [ACC_W:0]   max_v;
        logic signed [ACC_W-1:0] r;
        max_v = {2'b00, {(ACC_W-1){1'b1}}};
        sum_v = {acc[ACC_W-1], acc} + {{(ACC_W-W){e[W]}}, e};
        if (sum_v > max_v) begin
            r = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (sum_v < -max_v) begin
            r = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
        end else begin
            r = sum_v[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/el_timing_ctrl_if.sv
// el_timing_ctrl_if: sampler-side and phase-slip-side signals of the timing
// controller.
//   s_e, s_d   - early / late samples (signed, W bits)
//   el_valid   - one-cycle pulse marking a new sample pair
//   loop_en    - loop enable
//   adv, ret   - one-cycle phase advance / retard commands
//   err_out    - signed window error sum (ACC_W bits), err_valid marks updates
//   lock       - timing lock flag
// master: drives samples and enable; slave: the controller.
interface el_timing_ctrl_if;

    logic signed [el_timing_pkg::W-1:0]     s_e;
    logic signed [el_timing_pkg::W-1:0]     s_d;
    logic                                   el_valid;
    logic                                   loop_en;
    logic                                   adv;
    logic                                   ret;
    logic signed [el_timing_pkg::ACC_W-1:0] err_out;
    logic                                   err_valid;
    logic                                   lock;

    modport master (
        output s_e, s_d, el_valid, loop_en,
        input  adv, ret, err_out, err_valid, lock
    );

    modport slave (
        input  s_e, s_d, el_valid, loop_en,
        output adv, ret, err_out, err_valid, lock
    );

endinterface

// File: rtl/el_err_acc.sv
// el_err_acc: per-pair timing error e = |s_e| - |s_d| and its saturating
// running sum.
//   clk4, reset - clock and synchronous active-high reset
//   clr         - zero the accumulator (wins over en)
//   en          - add the current pair's error
//   s_e, s_d    - early / late samples
//   acc_sum     - registered running sum
//   acc_next    - running sum including the current pair's error
module el_err_acc
    import el_timing_pkg::*;
(
    input  logic                    clk4,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [W-1:0]     s_e,
    input  logic signed [W-1:0]     s_d,
    output logic signed [ACC_W-1:0] acc_sum,
    output logic signed [ACC_W-1:0] acc_next
);

    logic signed [W:0]       err_s;
    logic signed [ACC_W-1:0] acc_r;

    // Magnitudes are both in [0, 2^(W-1)-1], so a W+1-bit difference never wraps
    always_comb begin
        err_s    = {1'b0, abs_sat(s_e)} - {1'b0, abs_sat(s_d)};
        acc_next = sat_add(acc_r, err_s);
    end

    // Accumulator register
    always_ff @(posedge clk4) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= acc_next;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc_sum = acc_r;

endmodule

// File: rtl/el_timing_ctrl.sv
// el_timing_ctrl: early-late symbol timing controller. Averages the early/late
// magnitude error over N_AVG symbols and, at each window end, issues a single
// advance or retard pulse when the sum leaves [-THRESH, THRESH]; HOLD_SYM
// symbols are then discarded while the slip settles. LOCK_N consecutive
// in-band windows raise lock.
//   clk4, reset - 4x symbol clock, synchronous active-high reset
//   bus         - el_timing_ctrl_if slave (samples in; adv/ret/err/lock out)
module el_timing_ctrl
    import el_timing_pkg::*;
#(
    parameter int N_AVG    = 16,
    parameter int THRESH   = 2048,
    parameter int HOLD_SYM = 4,
    parameter int LOCK_N   = 4
)(
    input  logic             clk4,
    input  logic             reset,
    el_timing_ctrl_if.slave  bus
);

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0]        SYM_LAST  = CNT_W'(N_AVG - 1);
    localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(HOLD_SYM - 1);
    localparam logic [CNT_W-1:0]        LOCK_MAX  = CNT_W'(LOCK_N);
    localparam logic signed [ACC_W-1:0] THR_POS   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG   = ACC_W'(-THRESH);

    el_state_e               state_r, state_n;
    logic [CNT_W-1:0]        sym_cnt_r, sym_cnt_n;
    logic [CNT_W-1:0]        hold_cnt_r, hold_cnt_n;
    logic [CNT_W-1:0]        lock_cnt_r, lock_cnt_n;
    logic                    lock_r, lock_n;
    logic                    adv_r, adv_n;
    logic                    ret_r, ret_n;
    logic                    err_valid_r, err_valid_n;
    logic signed [ACC_W-1:0] err_out_r, err_out_n;
    logic                    acc_clr_s, acc_en_s;
    logic signed [ACC_W-1:0] acc_sum_s, acc_next_s, win_sum_s;

    el_err_acc u_err_acc (
        .clk4     (clk4),
        .reset    (reset),
        .clr      (acc_clr_s),
        .en       (acc_en_s),
        .s_e      (bus.s_e),
        .s_d      (bus.s_d),
        .acc_sum  (acc_sum_s),
        .acc_next (acc_next_s)
    );

    // Window sum as seen by the decision: includes the closing pair when it is accepted
    always_comb begin
        if (acc_en_s) begin
            win_sum_s = acc_next_s;
        end else begin
            win_sum_s = acc_sum_s;
        end
    end

    // Next-state, counter, decision and lock logic
    always_comb begin
        state_n     = state_r;
        sym_cnt_n   = sym_cnt_r;
        hold_cnt_n  = hold_cnt_r;
        lock_cnt_n  = lock_cnt_r;
        lock_n      = lock_r;
        adv_n       = 1'b0;
        ret_n       = 1'b0;
        err_valid_n = 1'b0;
        err_out_n   = err_out_r;
        acc_clr_s   = 1'b1;
        acc_en_s    = 1'b0;
        if (!bus.loop_en) begin
            // Abort: the pending window is dropped silently, err_out is kept
            state_n    = IDLE;
            sym_cnt_n  = {CNT_W{1'b0}};
            hold_cnt_n = {CNT_W{1'b0}};
            lock_cnt_n = {CNT_W{1'b0}};
            lock_n     = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = ACC;
                end
                ACC: begin
                    acc_clr_s = 1'b0;
                    if (bus.el_valid) begin
                        acc_en_s = 1'b1;
                        if (sym_cnt_r == SYM_LAST) begin
                            acc_clr_s   = 1'b1;
                            sym_cnt_n   = {CNT_W{1'b0}};
                            err_out_n   = win_sum_s;
                            err_valid_n = 1'b1;
                            if (win_sum_s > THR_POS) begin
                                adv_n      = 1'b1;
                                lock_cnt_n = {CNT_W{1'b0}};
                                lock_n     = 1'b0;
                                hold_cnt_n = {CNT_W{1'b0}};
                                state_n    = HOLD;
                            end else if (win_sum_s < THR_NEG) begin
                                ret_n      = 1'b1;
                                lock_cnt_n = {CNT_W{1'b0}};
                                lock_n     = 1'b0;
                                hold_cnt_n = {CNT_W{1'b0}};
                                state_n    = HOLD;
                            end else begin
                                if (lock_cnt_r < LOCK_MAX) begin
                                    lock_cnt_n = lock_cnt_r + 1'b1;
                                end else begin
                                    lock_cnt_n = LOCK_MAX;
                                end
                                lock_n = (lock_cnt_n == LOCK_MAX);
                            end
                        end else begin
                            sym_cnt_n = sym_cnt_r + 1'b1;
                        end
                    end else begin
                        sym_cnt_n = sym_cnt_r;
                    end
                end
                HOLD: begin
                    if (bus.el_valid) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            hold_cnt_n = {CNT_W{1'b0}};
                            state_n    = ACC;
                        end else begin
                            hold_cnt_n = hold_cnt_r + 1'b1;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt_r;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk4) begin
        if (reset) begin
            state_r     <= IDLE;
            sym_cnt_r   <= {CNT_W{1'b0}};
            hold_cnt_r  <= {CNT_W{1'b0}};
            lock_cnt_r  <= {CNT_W{1'b0}};
            lock_r      <= 1'b0;
            adv_r       <= 1'b0;
            ret_r       <= 1'b0;
            err_valid_r <= 1'b0;
            err_out_r   <= {ACC_W{1'b0}};
        end else begin
            state_r     <= state_n;
            sym_cnt_r   <= sym_cnt_n;
            hold_cnt_r  <= hold_cnt_n;
            lock_cnt_r  <= lock_cnt_n;
            lock_r      <= lock_n;
            adv_r       <= adv_n;
            ret_r       <= ret_n;
            err_valid_r <= err_valid_n;
            err_out_r   <= err_out_n;
        end
    end

    assign bus.adv       = adv_r;
    assign bus.ret       = ret_r;
    assign bus.err_valid = err_valid_r;
    assign bus.err_out   = err_out_r;
    assign bus.lock      = lock_r;

endmodule

// File: tb/tb_el_timing_ctrl.sv
// tb_el_timing_ctrl: scoreboard bench for el_timing_ctrl. Stimulus feeds a
// behavioural reference model that pushes expected window results; a monitor
// pops and compares whenever err_valid is seen.
module tb_el_timing_ctrl;
    import el_timing_pkg::*;

    localparam int N_AVG    = 16;
    localparam int THRESH   = 2048;
    localparam int HOLD_SYM = 4;
    localparam int LOCK_N   = 4;
    localparam int SAT      = 8388607;

    logic clk4 = 1'b0;
    logic reset;

    el_timing_ctrl_if bus();

    el_timing_ctrl #(
        .N_AVG    (N_AVG),
        .THRESH   (THRESH),
        .HOLD_SYM (HOLD_SYM),
        .LOCK_N   (LOCK_N)
    ) dut (
        .clk4  (clk4),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk4 = ~clk4;

    typedef struct {
        int sum;
        bit adv;
        bit ret;
        bit lock;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    bit m_hold;
    int m_hold_cnt, m_cnt, m_sum, m_lock_cnt, m_last_err;

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int absat(int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_clear();
        m_hold = 1'b0; m_hold_cnt = 0; m_cnt = 0; m_sum = 0; m_lock_cnt = 0;
    endtask

    task automatic model_pair(int se, int sd);
        res_t r;
        if (m_hold) begin
            m_hold_cnt++;
            if (m_hold_cnt == HOLD_SYM) begin
                m_hold = 1'b0;
                m_hold_cnt = 0;
            end
        end else begin
            m_sum = m_sum + absat(se) - absat(sd);
            if (m_sum > SAT) m_sum = SAT;
            if (m_sum < -SAT) m_sum = -SAT;
            m_cnt++;
            if (m_cnt == N_AVG) begin
                r.sum = m_sum;
                r.adv = (m_sum > THRESH);
                r.ret = (m_sum < -THRESH);
                if (r.adv || r.ret) begin
                    m_lock_cnt = 0;
                    m_hold = 1'b1;
                end else if (m_lock_cnt < LOCK_N) begin
                    m_lock_cnt++;
                end
                r.lock = (m_lock_cnt == LOCK_N);
                exp_q.push_back(r);
                m_last_err = m_sum;
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    // Issue one pair at a negedge, then idle for gap cycles
    task automatic pair(int se, int sd, int gap);
        bus.s_e = W'(se);
        bus.s_d = W'(sd);
        bus.el_valid = 1'b1;
        model_pair(se, sd);
        @(negedge clk4);
        bus.el_valid = 1'b0;
        repeat (gap) @(negedge clk4);
    endtask

    task automatic pairs(int n, int se, int sd);
        for (int i = 0; i < n; i++) pair(se, sd, 0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk4);
    endtask

    // Monitor: pulses only with err_valid, and every window result matches the model
    always @(negedge clk4) begin
        res_t r;
        if (!reset) begin
            if (bus.adv || bus.ret) begin
                chk("adv_ret_exclusive", longint'(bus.adv & bus.ret), 0);
                chk("pulse_with_err_valid", longint'(bus.err_valid), 1);
            end
            if (bus.err_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_err_valid", longint'(bus.err_valid), 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("err_out", longint'(bus.err_out), longint'(r.sum));
                    chk("adv", longint'(bus.adv), longint'(r.adv));
                    chk("ret", longint'(bus.ret), longint'(r.ret));
                    chk("lock", longint'(bus.lock), longint'(r.lock));
                end
            end
        end
    end

    initial begin
        int se, sd, a, sg, kind;
        reset        = 1'b1;
        bus.s_e      = '0;
        bus.s_d      = '0;
        bus.el_valid = 1'b0;
        bus.loop_en  = 1'b0;
        model_clear();
        m_last_err = 0;
        repeat (3) @(negedge clk4);
        chk("rst_adv", longint'(bus.adv), 0);
        chk("rst_ret", longint'(bus.ret), 0);
        chk("rst_err_valid", longint'(bus.err_valid), 0);
        chk("rst_err_out", longint'(bus.err_out), 0);
        chk("rst_lock", longint'(bus.lock), 0);
        reset = 1'b0;
        @(negedge clk4);
        bus.loop_en = 1'b1;
        repeat (2) @(negedge clk4);

        // early stronger, then HOLD discard, then late stronger
        pairs(N_AVG, 1000, 400);
        pairs(HOLD_SYM, 0, 30000);
        pairs(N_AVG, 400, 1000);
        // balanced windows build lock, then a correction drops it
        pairs(HOLD_SYM, 7, 3);
        pairs(4 * N_AVG, 5000, 5000);
        pairs(N_AVG, 2000, 0);
        // threshold boundary: 2048 in-band, 2049 corrects
        pairs(HOLD_SYM, 1, 2);
        pairs(N_AVG, 128, 0);
        pairs(N_AVG - 1, 128, 0);
        pair(129, 0, 0);
        // saturated magnitude of the most negative sample
        pairs(HOLD_SYM, 0, 0);
        pairs(N_AVG, -32768, 0);
        pairs(HOLD_SYM, 0, 0);
        settle();

        // abort mid-window: no result, lock clear, err_out held
        pairs(10, 1000, 400);
        bus.loop_en = 1'b0;
        model_clear();
        settle();
        chk("abort_lock", longint'(bus.lock), 0);
        chk("abort_err_out_held", longint'(bus.err_out), longint'(m_last_err));
        bus.loop_en = 1'b1;
        repeat (2) @(negedge clk4);
        pairs(N_AVG, 1000, 400);
        pairs(HOLD_SYM, 0, 0);

        // randomized stream with gaps; holds handled by the model
        for (int w = 0; w < 20 * N_AVG; w++) begin
            kind = int'($urandom_range(0, 2));
            sg = ($urandom_range(0, 1) != 0) ? -1 : 1;
            if (kind == 0) begin
                a  = int'($urandom_range(0, 20000));
                se = sg * a;
                sd = (($urandom_range(0, 1) != 0) ? -1 : 1) * (a + int'($urandom_range(0, 400)) - 200);
            end else begin
                se = int'($urandom_range(0, 65535)) - 32768;
                sd = int'($urandom_range(0, 65535)) - 32768;
            end
            pair(se, sd, int'($urandom_range(0, 2)));
        end
        settle();

        // reset mid-window clears every output
        pairs(5, 3000, 100);
        reset = 1'b1;
        @(negedge clk4);
        chk("mid_rst_adv", longint'(bus.adv), 0);
        chk("mid_rst_ret", longint'(bus.ret), 0);
        chk("mid_rst_err_valid", longint'(bus.err_valid), 0);
        chk("mid_rst_err_out", longint'(bus.err_out), 0);
        chk("mid_rst_lock", longint'(bus.lock), 0);
        model_clear();
        m_last_err = 0;
        reset = 1'b0;
        settle();
        chk("results_pending", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/el_timing_ctrl.md
# el_timing_ctrl

Early-late timing controller for the 4x-oversampled symbol timing recovery loop. Consumes the early and late sample pair produced once per symbol by the early/late sampler, forms a magnitude-difference timing error, and averages it over a window of symbols. At the end of each window it issues a one-cycle advance or retard command that slips the sampling phase by one clk4 period. Sits directly downstream of the early/late sampler and drives the phase-slip input of the sampling counter.

## Interface
- W, 16, sample width (signed two's complement)
- ACC_W, 24, error accumulator width (signed)
- N_AVG, 16, symbols per decision window (2..256)
- THRESH, 2048, decision threshold (positive, < 2^(ACC_W-1))
- HOLD_SYM, 4, symbols discarded after a correction
- LOCK_N, 4, consecutive in-band windows required to declare lock

- clk4  in  1  clock, 4x symbol rate
- reset  in  1  synchronous, active-high
- s_e  in  W  early sample, signed
- s_d  in  W  late sample, signed
- el_valid  in  1  one-cycle pulse; s_e/s_d form a new pair this cycle
- loop_en  in  1  loop enable; low forces IDLE
- adv  out  1  one-cycle pulse: advance sampling phase by one clk4
- ret  out  1  one-cycle pulse: retard sampling phase by one clk4
- err_out  out  ACC_W  signed window sum, held until next window end
- err_valid  out  1  one-cycle pulse when err_out updates
- lock  out  1  timing lock flag

## Operation
- Per pair: e = |s_e| - |s_d|; |x| saturates, so |-2^(W-1)| = 2^(W-1)-1; e is W+1 bits signed.
- acc accumulates e, sign-extended to ACC_W, saturating at ±(2^(ACC_W-1)-1).
- States: IDLE, ACC, HOLD.
- IDLE: acc=0, sym_cnt=0, hold_cnt=0, lock=0; goes to ACC when loop_en=1.
- ACC: each el_valid adds e and increments sym_cnt. On the N_AVG-th el_valid, the window closes. The window sum includes that pair's e.
  - err_out <= sum; err_valid pulses.
  - sum > THRESH: adv pulses, lock_cnt=0, lock=0, then HOLD.
  - sum < -THRESH: ret pulses, lock_cnt=0, lock=0, then HOLD.
  - Otherwise there is no pulse and the state stays ACC. lock_cnt increments, saturating at LOCK_N; lock=1 once lock_cnt=LOCK_N.
  - acc and sym_cnt clear for the next window.
- Sum exactly equal to ±THRESH is in-band (no correction).
- HOLD: counts HOLD_SYM el_valid pulses, whose samples are discarded. The HOLD_SYM-th pulse moves the state to ACC, with acc=0. The first accumulated pair is the next el_valid.
- loop_en low in any state: go to IDLE next cycle. acc, counters and lock clear; no adv/ret/err_valid is issued for the aborted window. err_out holds its value.
- adv and ret are never high together; each lasts exactly one cycle.

## Timing
- Reset values: adv=0, ret=0, err_valid=0, err_out=0, lock=0, state=IDLE, all counters 0.
- Latency: el_valid of the closing pair at edge t → adv/ret/err_valid/err_out/lock visible after edge t (one clk4 cycle).
- el_valid is sampled only while loop_en=1 in the same cycle. Back-to-back el_valid on consecutive cycles must be accepted (no throughput limit).
- An el_valid on the same edge that loop_en falls is discarded.
- Reset mid-window behaves as IDLE entry, and additionally clears err_out.
- Minimum spacing between corrections: N_AVG + HOLD_SYM symbols.

## Structure
- Shared package `el_timing_pkg`:
  - W and ACC_W defaults
  - state enum {IDLE, ACC, HOLD}
  - function abs_sat(W-bit signed) → W-bit
  - function sat_add(ACC_W-bit, (W+1)-bit) → ACC_W-bit
- Sub-module `el_err_acc`:
  - abs/difference plus saturating accumulator, with clear and enable inputs; outputs the current sum and the next sum.
  - The top level holds the FSM, counters, decision logic and lock.

## Test plan
- Early stronger: loop_en=1, 16 pairs s_e=1000, s_d=400 → err_out=9600, one adv pulse one cycle after the 16th el_valid, ret=0.
- HOLD behaviour:
  - After the adv above, 4 pairs s_e=0, s_d=30000 must not change acc.
  - Then 16 pairs s_e=400, s_d=1000 → err_out=-9600 and one ret pulse.
- Balanced and lock:
  - 4 windows of s_e=s_d=5000 → err_out=0 each window, no adv/ret, lock rises after the 4th err_valid.
  - A following window of s_e=2000, s_d=0 → adv pulse and lock=0.
- Threshold boundary:
  - Window sum exactly 2048 (15 pairs e=128, 1 pair e=128) → no pulse.
  - Window sum 2049 → adv pulse.
- Saturation: s_e=-32768, s_d=0 for 16 pairs → per-pair e=32767, err_out=524272, adv pulse.
- Abort and reset:
  - loop_en dropped after 10 pairs → no err_valid, lock=0. Re-enabling starts a fresh 16-pair window.
  - reset asserted mid-window → all outputs 0 on the next cycle.
